asmd_decryption: RTL and testbench
==================================

// Module: asmd_decryption
// PURPOSE
//  Iterative AES-128 decryption engine (FIPS-197 inverse cipher). It is the receive-side partner of the
//  ASMD encryption block and uses the same start/done handshake and the same key format.
//  Expands the 128-bit key into an 11-entry round-key register file, then applies one inverse round per
//  clock. Plaintext appears on Data_OUT with a done strobe. The block sits beside the encryption ASMD in
//  the AES top level.
// PARAMETERS
//  NR          10  number of rounds; only 10 (AES-128) is supported, other values are illegal
//  DONE_PULSE  1   1: done is a single-cycle pulse; 0: done is held high until the next accepted decrypt
// PORTS
//  clock        in   1    rising-edge clock
//  reset        in   1    synchronous, active-high reset
//  decrypt      in   1    start request; sampled only in IDLE
//  cipher_text  in   128  ciphertext; bit 127 = byte 0 = s[0][0], column-major per FIPS-197
//  key          in   128  cipher key, same byte order as cipher_text
//  Data_OUT     out  128  recovered plaintext, registered
//  done         out  1    result valid on Data_OUT
//  busy         out  1    high from the accept edge until the final-round edge
// BEHAVIOUR
//  Reset (reset=1 at a rising edge):
//   - state=IDLE; Data_OUT=0; done=0; busy=0; round counter=0; round-key file cleared.
//   - Reset wins over every other event, including mid-operation. The partial result is discarded.
//  FSM states: IDLE -> KEYEXP -> ADDKEY -> ROUND -> FINAL -> IDLE.
//  IDLE:
//   - On edge E0 with decrypt=1: latch cipher_text and key into internal registers; rk[0]=key; cnt=1;
//     busy=1.
//   - With DONE_PULSE=1, done clears at E0.
//   - cipher_text and key may change after E0 without effect on the running operation.
//  KEYEXP (edges E1..E10):
//   - rk[cnt] = standard expansion of rk[cnt-1], using SubWord, RotWord and Rcon.
//   - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. cnt increments each edge.
//  ADDKEY (edge E11): state = ct ^ rk[10]; cnt=9.
//  ROUND (edges E12..E20, cnt 9 down to 1):
//   - state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[cnt]).
//  FINAL (edge E21):
//   - Data_OUT = InvSubBytes(InvShiftRows(state)) ^ rk[0]; done=1; busy=0; next state IDLE.
//  Latency and handshake:
//   - done is high in the cycle after E21, i.e. 21 cycles after the accepting edge.
//   - DONE_PULSE=1: done drops at the next edge unless a new result completes.
//   - Data_OUT holds its value until the next FINAL edge or reset.
//  Back-to-back: decrypt=1 in the done cycle is accepted at E22, with no bubble.
//   - decrypt held high continuously gives one result every 22 cycles.
//  decrypt while busy=1 is ignored; it is not queued.
//  Arithmetic: all GF(2^8) operations use modulus x^8+x^4+x^3+x+1.
//   - InvMixColumns matrix {0e,0b,0d,09}.
//   - Inverse S-box for the data path; forward S-box for key expansion only.
//   - Both S-boxes are combinational lookups, no RAM.
// TESTING
//  1. FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a
//     -> Data_OUT=00112233445566778899aabbccddeeff, with done exactly 21 cycles after the accept edge.
//  2. FIPS-197 App.B: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32
//     -> Data_OUT=3243f6a8885a308d313198a2e0370734.
//  3. Round trip: encryption block with key=pt=49206c6f76652063686f636f6c617465; feed its Data_OUT as
//     cipher_text with the same key -> Data_OUT=49206c6f76652063686f636f6c617465.
//  4. Assert reset at cycle 8 of an operation -> next cycle Data_OUT=0, done=0, busy=0.
//     A new decrypt of vector 1 then completes correctly.
//  5. Pulse decrypt during busy with vector 2 -> ignored; vector 1 result is unchanged and no second
//     done occurs.
//  6. Hold decrypt=1 with vectors 1 then 2 -> done at cycles 21 and 43; Data_OUT correct for each.
//     With DONE_PULSE=0, done stays high between results.

Source files
------------

// File: rtl/asmd_decryption.sv
// Iterative AES-128 inverse cipher: expands the key into an 11-entry round-key file,
// then runs one inverse round per clock behind a decrypt/done handshake.
module asmd_decryption #(
  parameter int unsigned NR         = 10,
  parameter bit          DONE_PULSE = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         decrypt,
  input  logic [127:0] cipher_text,
  input  logic [127:0] key,
  output logic [127:0] Data_OUT,
  output logic         done,
  output logic         busy
);
  localparam int unsigned BW = 128;
  localparam int unsigned CW = 4;
  localparam int unsigned NK = NR + 1;

  if (NR != 10) begin : g_nr_check
    $error("asmd_decryption: only NR=10 (AES-128) is supported");
  end

  // Byte 0 (s[0][0]) sits in bits 127:120; byte n is row n%4, column n/4.
  typedef logic [0:15][7:0] blk_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_ADDKEY,
    S_ROUND,
    S_FINAL
  } state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] ISBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2040 - {x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2040 - {x, 3'b000};
    return ISBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the AES-128 key schedule: four new words from the previous round key.
  function automatic logic [BW-1:0] expand(input logic [BW-1:0] rk, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = w3         ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // InvShiftRows (row r rotates right by r) fused with InvSubBytes.
  function automatic blk_t inv_shift_sub(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[4'(w + 4 * c)] = inv_sbox(s[4'(w + 4 * ((c - w) & 3))]);
      end
    end
    return r;
  endfunction

  function automatic blk_t inv_mix(input blk_t s);
    blk_t r;
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        a[k]  = s[4'(4 * c + k)];
        m2[k] = xt(a[k]);
        m4[k] = xt(m2[k]);
        m8[k] = xt(m4[k]);
      end
      // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
      r[4'(4 * c)]     = (m8[0]^m4[0]^m2[0]) ^ (m8[1]^m2[1]^a[1]) ^ (m8[2]^m4[2]^a[2]) ^ (m8[3]^a[3]);
      r[4'(4 * c + 1)] = (m8[0]^a[0]) ^ (m8[1]^m4[1]^m2[1]) ^ (m8[2]^m2[2]^a[2]) ^ (m8[3]^m4[3]^a[3]);
      r[4'(4 * c + 2)] = (m8[0]^m4[0]^a[0]) ^ (m8[1]^a[1]) ^ (m8[2]^m4[2]^m2[2]) ^ (m8[3]^m2[3]^a[3]);
      r[4'(4 * c + 3)] = (m8[0]^m2[0]^a[0]) ^ (m8[1]^m4[1]^a[1]) ^ (m8[2]^a[2]) ^ (m8[3]^m4[3]^m2[3]);
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   ct_q, ct_d;
  logic [BW-1:0]   st_q, st_d;
  logic [BW-1:0]   rk_q [NK];
  logic [BW-1:0]   rk_d [NK];
  logic [BW-1:0]   dout_q, dout_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [BW-1:0]   iss_c;
  logic [BW-1:0]   rk_sel_c;
  logic [BW-1:0]   rk_next_c;

  assign iss_c     = inv_shift_sub(st_q);
  assign rk_sel_c  = rk_q[cnt_q];
  assign rk_next_c = expand(rk_q[cnt_q - CW'(1)], rcon(cnt_q));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ct_q    <= '0;
      st_q    <= '0;
      rk_q    <= '{default: '0};
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    st_d    = st_q;
    rk_d    = rk_q;
    dout_d  = dout_q;
    done_d  = DONE_PULSE ? 1'b0 : done_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (decrypt) begin
          ct_d    = cipher_text;
          rk_d[0] = key;
          cnt_d   = CW'(1);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        rk_d[cnt_q] = rk_next_c;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == CW'(NR)) state_d = S_ADDKEY;
      end
      S_ADDKEY: begin
        st_d    = ct_q ^ rk_q[NR];
        cnt_d   = CW'(NR - 1);
        state_d = S_ROUND;
      end
      S_ROUND: begin
        st_d  = inv_mix(iss_c ^ rk_sel_c);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        dout_d  = iss_c ^ rk_q[0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Data_OUT = dout_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_asmd_decryption.sv
// Bench for asmd_decryption: FIPS-197 vectors plus random plaintexts run through a
// forward-cipher model, with handshake, reset and back-to-back checks.
module tb_asmd_decryption;
  logic         clock = 1'b0;
  logic         reset;
  logic         decrypt;
  logic [127:0] cipher_text;
  logic [127:0] key;
  logic [127:0] Data_OUT;
  logic         done;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RT3 = 128'h49206c6f76652063686f636f6c617465;

  asmd_decryption dut (
    .clock       (clock),
    .reset       (reset),
    .decrypt     (decrypt),
    .cipher_text (cipher_text),
    .key         (key),
    .Data_OUT    (Data_OUT),
    .done        (done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  // Reference forward AES-128 cipher; decryption is checked by recovering its input.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w0 = 0; w0 < 4; w0++) s[w0 + 4 * c] = t[w0 + 4 * ((c + w0) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present a request for one edge; afterwards the inputs are scrambled.
  task automatic start_op(input logic [127:0] ct, input logic [127:0] k);
    @(negedge clock);
    decrypt = 1'b1; cipher_text = ct; key = k;
    @(negedge clock);
    decrypt = 1'b0; cipher_text = rnd128(); key = rnd128();
  endtask

  // Counts cycles after the accepting edge until done, bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 80) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_one(input string tag, input logic [127:0] ct, input logic [127:0] k,
                         input logic [127:0] exp);
    int n;
    start_op(ct, k);
    check({tag, ".busy_start"}, 128'(busy), 128'(1));
    wait_done(0, n);
    check({tag, ".latency"}, 128'(n), 128'(21));
    check({tag, ".data"}, Data_OUT, exp);
    check({tag, ".busy_end"}, 128'(busy), 128'(0));
    @(negedge clock);
    check({tag, ".done_pulse"}, 128'(done), 128'(0));
    check({tag, ".data_hold"}, Data_OUT, exp);
  endtask

  initial begin
    int n, dcount;
    logic [127:0] pt, k;
    reset = 1'b1; decrypt = 1'b0; cipher_text = '0; key = '0;
    build_sbox();
    repeat (3) @(negedge clock);
    check("reset.data", Data_OUT, 128'h0);
    check("reset.done", 128'(done), 128'(0));
    check("reset.busy", 128'(busy), 128'(0));
    reset = 1'b0;
    @(negedge clock);
    check("idle.done", 128'(done), 128'(0));

    run_one("fips_c1", C1, K1, P1);
    run_one("fips_b", C2, K2, P2);
    run_one("roundtrip", aes_enc(RT3, RT3), RT3, RT3);
    for (int i = 0; i < 8; i++) begin
      pt = rnd128(); k = rnd128();
      run_one($sformatf("rand%0d", i), aes_enc(pt, k), k, pt);
    end

    // Reset in the middle of an operation.
    start_op(C2, K2);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset.data", Data_OUT, 128'h0);
    check("midreset.done", 128'(done), 128'(0));
    check("midreset.busy", 128'(busy), 128'(0));
    run_one("after_reset", C1, K1, P1);

    // A request while busy is dropped.
    start_op(C1, K1);
    repeat (4) @(negedge clock);
    decrypt = 1'b1; cipher_text = C2; key = K2;
    @(negedge clock);
    decrypt = 1'b0;
    wait_done(5, n);
    check("busyreq.latency", 128'(n), 128'(21));
    check("busyreq.data", Data_OUT, P1);
    dcount = 0;
    repeat (30) begin
      @(negedge clock);
      if (done === 1'b1) dcount++;
    end
    check("busyreq.no_second_done", 128'(dcount), 128'(0));
    check("busyreq.data_hold", Data_OUT, P1);

    // decrypt held high: back-to-back operations with no bubble.
    @(negedge clock);
    decrypt = 1'b1; cipher_text = C1; key = K1;
    @(negedge clock);
    cipher_text = C2; key = K2;
    wait_done(0, n);
    check("b2b.first_latency", 128'(n), 128'(21));
    check("b2b.first_data", Data_OUT, P1);
    @(negedge clock);
    n++;
    check("b2b.reaccept_done", 128'(done), 128'(0));
    check("b2b.reaccept_busy", 128'(busy), 128'(1));
    wait_done(n, n);
    decrypt = 1'b0;
    check("b2b.second_latency", 128'(n), 128'(43));
    check("b2b.second_data", Data_OUT, P2);
    @(negedge clock);
    check("b2b.idle_busy", 128'(busy), 128'(0));
    check("b2b.idle_done", 128'(done), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
